// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg: shared UART constants and receiver state encoding.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int unsigned DEF_CLK_FREQ  = 50_000_000;
  localparam int unsigned DEF_BAUD_RATE = 9600;
  localparam int unsigned DATA_BITS     = 8;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff: 1-bit two-flop synchroniser, async active-low reset.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx: 8N1 UART receiver, mid-bit sampling from a baud counter.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
  parameter int unsigned BAUD_RATE = DEF_BAUD_RATE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned CPB   = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CPB - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  if (CPB < 4) begin : g_cpb_too_small
    $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
  end

  logic rx_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync_rx (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  state_t               state_d, state_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic [IDX_W-1:0]     idx_d, idx_q;
  logic [DATA_BITS-1:0] shift_d, shift_q;
  logic [DATA_BITS-1:0] data_d, data_q;
  logic                 valid_d, valid_q;
  logic                 ferr_d, ferr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      // A start bit that is high again at mid-bit is treated as a glitch.
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == LAST_IDX) state_d = STOP;
          else                   idx_d   = idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // A break must end before another start edge can be recognised.
      WAIT_IDLE: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx: directed self-checking bench for uart_rx at 16 clocks per bit.
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.CLK_FREQ(16), .BAUD_RATE(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_valid = 0;
  int         n_ferr  = 0;
  int         n_both  = 0;
  int         last_valid_cyc = 0;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      last_valid_cyc = cyc;
      got_q.push_back(rx_data);
    end
    if (frame_err) n_ferr++;
    if (rx_valid && frame_err) n_both++;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    n_valid = 0;
    n_ferr  = 0;
    got_q.delete();
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int fall_cyc);
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_data;
    int         exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int fall;
    int lat;

    vecs[0] = '{8'h15, 1'b1, 8'h15, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 8'h00, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
    vecs[3] = '{8'h80, 1'b1, 8'h80, 1, 0};
    vecs[4] = '{8'h5A, 1'b0, 8'h80, 0, 1};
    vecs[5] = '{8'h01, 1'b1, 8'h01, 1, 0};

    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_busy", busy, 0);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      clear_mon();
      send_frame(vecs[i].data, vecs[i].stop, fall);
      rx = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid_count", i), n_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_ferr_count", i), n_ferr, vecs[i].exp_ferr);
      chk($sformatf("vec%0d_rx_data", i), rx_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_busy_idle", i), busy, 0);
      if (i == 0) begin
        lat = last_valid_cyc - fall;
        chk("latency_clk", (lat >= 154 && lat <= 156) ? 155 : lat, 155);
      end
    end

    // Back-to-back frames with no idle gap
    clear_mon();
    send_frame(8'h13, 1'b1, fall);
    send_frame(8'h2A, 1'b1, fall);
    repeat (20) @(posedge clk);
    #1;
    chk("b2b_valid_count", n_valid, 2);
    chk("b2b_first", (got_q.size() > 0) ? int'(got_q[0]) : -1, 8'h13);
    chk("b2b_second", (got_q.size() > 1) ? int'(got_q[1]) : -1, 8'h2A);
    chk("b2b_rx_data", rx_data, 8'h2A);

    // Short low glitch aborts in START
    clear_mon();
    rx = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("glitch_busy_in_start", busy, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("glitch_busy_after", busy, 0);
    chk("glitch_valid_count", n_valid, 0);
    chk("glitch_ferr_count", n_ferr, 0);
    chk("glitch_rx_data", rx_data, 8'h2A);

    // Low stop bit followed by a held break
    clear_mon();
    send_frame(8'hA5, 1'b0, fall);
    repeat (40) @(posedge clk);
    #1;
    chk("break_ferr_count", n_ferr, 1);
    chk("break_valid_count", n_valid, 0);
    chk("break_rx_data", rx_data, 8'h2A);
    chk("break_busy_held", busy, 1);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("break_busy_released", busy, 0);

    // Reset in the middle of data bit 4 of 0xFF
    clear_mon();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (8) @(posedge clk);
    #1;
    chk("midreset_busy_before", busy, 1);
    reset = 1'b0;
    #2;
    chk("midreset_rx_data", rx_data, 8'h00);
    chk("midreset_busy", busy, 0);
    chk("midreset_valid", rx_valid, 0);
    chk("midreset_ferr", frame_err, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("midreset_no_pulse", n_valid + n_ferr, 0);
    send_frame(8'h21, 1'b1, fall);
    repeat (20) @(posedge clk);
    #1;
    chk("after_reset_valid_count", n_valid, 1);
    chk("after_reset_rx_data", rx_data, 8'h21);
    chk("after_reset_ferr_count", n_ferr, 0);

    chk("valid_ferr_overlap", n_both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
